// File: rtl/kalman_seq_pkg.sv
// Shared types and defaults for the kalman_sequencer slice.
package kalman_seq_pkg;

  localparam int unsigned DefDataW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFilter,
    StSendWait,
    StSend
  } state_e;

endpackage

// File: rtl/kalman_sequencer_if.sv
// Sensor / filter / serializer signal bundle; slave is the sequencer view, master the surroundings.
interface kalman_sequencer_if
  import kalman_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned CNT_W  = 8
);

    logic [DATA_W-1:0] z_in;
    logic              z_valid;
    logic              kf_start;
    logic [DATA_W-1:0] kf_z;
    logic              kf_done;
    logic [DATA_W-1:0] kf_x;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              clear_err;
    logic              busy;
    logic [CNT_W-1:0]  overrun_cnt;
    logic              err_timeout;

    modport slave (
        input  z_in, z_valid, kf_done, kf_x, tx_busy, clear_err,
        output kf_start, kf_z, tx_start, tx_data, busy, overrun_cnt, err_timeout
    );

    modport master (
        output z_in, z_valid, kf_done, kf_x, tx_busy, clear_err,
        input  kf_start, kf_z, tx_start, tx_data, busy, overrun_cnt, err_timeout
    );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by a registered
// one-cycle rising-edge pulse.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;
    logic              pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            last_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], din};
            last_q  <= sync_q[STAGES-1];
            pulse_q <= sync_q[STAGES-1] & ~last_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/kalman_sequencer.sv
// Sequences one filter run per sensor sample and forwards the posterior to the serializer.
// Optional FILTER watchdog enabled by defining KSEQ_WATCHDOG_EN.
module kalman_sequencer
  import kalman_seq_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input logic              clk,
    input logic              rst_n,
    kalman_sequencer_if.slave bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pending_q, result_q, kf_z_q, tx_data_q;
    logic              pending_vld_q, busy_q;
    logic [CNT_W-1:0]  ovr_q;
    logic              sample_evt, consume, launch_tx, overrun, timeout;

    sync_edge #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.z_valid),
        .pulse(sample_evt)
    );

    always_comb begin
        state_d   = state_q;
        consume   = 1'b0;
        launch_tx = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pending_vld_q) begin
                    consume = 1'b1;
                    state_d = StFilter;
                end
            end
            StFilter: begin
                // A done arriving in the timeout cycle still counts as in time.
                if (bus.kf_done) state_d = StSendWait;
                else if (timeout) state_d = StIdle;
            end
            StSendWait: begin
                if (!bus.tx_busy) begin
                    launch_tx = 1'b1;
                    state_d   = StSend;
                end
            end
            StSend:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A sample landing while IDLE drains pending is not an overrun.
    assign overrun = sample_evt & pending_vld_q & ~consume;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pending_q     <= '0;
            pending_vld_q <= 1'b0;
            result_q      <= '0;
            kf_z_q        <= '0;
            tx_data_q     <= '0;
            busy_q        <= 1'b0;
            ovr_q         <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
            if (sample_evt) pending_q <= bus.z_in;
            if (sample_evt) pending_vld_q <= 1'b1;
            else if (consume) pending_vld_q <= 1'b0;
            if (consume) kf_z_q <= pending_q;
            if (state_q == StFilter && bus.kf_done) result_q <= bus.kf_x;
            if (launch_tx) tx_data_q <= result_q;
            if (bus.clear_err) ovr_q <= '0;
            else if (overrun && ovr_q != '1) ovr_q <= ovr_q + 1'b1;
        end
    end

`ifdef KSEQ_WATCHDOG_EN
    localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);

    logic [WdogW-1:0] wdog_q;
    logic             err_q;

    assign timeout = (state_q == StFilter) && (wdog_q == WdogLast) && !bus.kf_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (consume) wdog_q <= '0;
            else if (state_q == StFilter) wdog_q <= wdog_q + 1'b1;
            if (bus.clear_err) err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;
        end
    end

    assign bus.err_timeout = err_q;
`else
    logic unused_wdog;
    assign unused_wdog     = (WDOG_CYCLES == 0);
    assign timeout         = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    // Pulses are Mealy so they fire in the cycle the condition holds; data muxes keep words
    // aligned with their pulse and held afterwards.
    assign bus.kf_start    = consume;
    assign bus.kf_z        = consume ? pending_q : kf_z_q;
    assign bus.tx_start    = launch_tx;
    assign bus.tx_data     = launch_tx ? result_q : tx_data_q;
    assign bus.busy        = busy_q;
    assign bus.overrun_cnt = ovr_q;

endmodule

// File: tb/tb_kalman_sequencer.sv
// Scoreboard bench for kalman_sequencer: random samples, filter and serializer responders,
// overrun, saturation, reset and watchdog scenarios.
module tb_kalman_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;
    localparam int unsigned WD = 48;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kalman_sequencer_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    kalman_sequencer #(
        .DATA_W     (DW),
        .SYNC_STAGES(2),
        .CNT_W      (CW),
        .WDOG_CYCLES(WD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_delay = 5;
    int rst_gen = 0;
    int done_cyc = -100;
    int zrise_cyc = -100;
    int tx_count = 0;
    bit hold_filter = 1'b0;
    bit chk_tx_lat = 1'b0;
    bit chk_kf_lat = 1'b0;
    bit ser_busy = 1'b0;
    bit force_busy = 1'b0;
    logic [DW-1:0] exp_kf[$];
    logic [DW-1:0] exp_tx[$];

    assign bus.tx_busy = ser_busy | force_busy;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] filt(input logic [DW-1:0] z);
        return z ^ DW'(16'h0034);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_sample(input logic [DW-1:0] v);
        @(posedge clk);
        #1;
        bus.z_in    = v;
        bus.z_valid = 1'b1;
        zrise_cyc   = cyc;
        repeat (5) @(posedge clk);
        #1 bus.z_valid = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((bus.busy || ser_busy || exp_kf.size() != 0 || exp_tx.size() != 0) && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (n >= limit) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", limit);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 bus.clear_err = 1'b1;
        @(posedge clk);
        #1 bus.clear_err = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_kf_start"}, 32'(bus.kf_start), 32'd0);
        check({tag, "_kf_z"}, 32'(bus.kf_z), 32'd0);
        check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_overrun_cnt"}, 32'(bus.overrun_cnt), 32'd0);
        check({tag, "_err_timeout"}, 32'(bus.err_timeout), 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT issues a pulse.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.kf_start) begin
                    if (exp_kf.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL kf_start_unexpected: got kf_z=%0h, required no start", bus.kf_z);
                    end else begin
                        e = exp_kf.pop_front();
                        check("kf_z", 32'(bus.kf_z), 32'(e));
                    end
                    if (chk_kf_lat) check("kf_start_latency", 32'(cyc - zrise_cyc), 32'd4);
                end
                if (bus.tx_start) begin
                    tx_count++;
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_start_unexpected: got tx_data=%0h, required no send",
                                 bus.tx_data);
                    end else begin
                        e = exp_tx.pop_front();
                        check("tx_data", 32'(bus.tx_data), 32'(e));
                    end
                    check("tx_busy_at_tx_start", 32'(bus.tx_busy), 32'd0);
                    if (chk_tx_lat) check("tx_start_latency", 32'(cyc - done_cyc), 32'd1);
                end
            end
        end
    end

    // Filter model: answers each start after done_delay cycles unless held or reset intervened.
    initial begin
        logic [DW-1:0] z;
        int g;
        bus.kf_done = 1'b0;
        bus.kf_x    = '0;
        forever begin
            @(negedge clk);
            if (bus.kf_start && rst_n) begin
                z = bus.kf_z;
                g = rst_gen;
                repeat (done_delay) @(posedge clk);
                while (hold_filter) @(posedge clk);
                #1;
                if (g == rst_gen) begin
                    bus.kf_x    = filt(z);
                    bus.kf_done = 1'b1;
                    done_cyc    = cyc;
                    @(posedge clk);
                    #1 bus.kf_done = 1'b0;
                end
            end
        end
    end

    // Serializer model: busy from the cycle after tx_start for a few cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_start && rst_n) begin
                @(posedge clk);
                #1 ser_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1 ser_busy = 1'b0;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [DW-1:0] v, a, b, c, last;
        int n0;
        bus.z_in      = '0;
        bus.z_valid   = 1'b0;
        bus.clear_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Single sample from the plan.
        done_delay = 5;
        chk_tx_lat = 1'b1;
        chk_kf_lat = 1'b1;
        exp_kf.push_back(16'h1234);
        exp_tx.push_back(16'h1200);
        send_sample(16'h1234);
        wait_idle(200);
        check("single_tx_data_held", 32'(bus.tx_data), 32'h1200);
        check("single_overrun", 32'(bus.overrun_cnt), 32'd0);

        // Random isolated samples.
        for (int i = 0; i < 8; i++) begin
            v = DW'($urandom);
            done_delay = $urandom_range(1, 8);
            exp_kf.push_back(v);
            exp_tx.push_back(filt(v));
            send_sample(v);
            wait_idle(200);
        end
        chk_kf_lat = 1'b0;

        // Serializer busy when done arrives.
        chk_tx_lat = 1'b0;
        force_busy = 1'b1;
        done_delay = 5;
        v = DW'($urandom);
        exp_kf.push_back(v);
        exp_tx.push_back(filt(v));
        n0 = tx_count;
        send_sample(v);
        repeat (20) @(posedge clk);
        #1;
        check("busy_tx_suppressed", 32'(tx_count), 32'(n0));
        @(posedge clk);
        #1 force_busy = 1'b0;
        @(negedge clk);
        check("busy_tx_first_free_cycle", 32'(bus.tx_start), 32'd1);
        wait_idle(200);
        check("busy_tx_single_pulse", 32'(tx_count), 32'(n0 + 1));

        // Three samples inside one FILTER window: A runs, B overwritten by C.
        chk_tx_lat = 1'b1;
        done_delay = 35;
        a = DW'($urandom);
        b = DW'($urandom);
        c = DW'($urandom);
        exp_kf.push_back(a);
        exp_kf.push_back(c);
        exp_tx.push_back(filt(a));
        exp_tx.push_back(filt(c));
        send_sample(a);
        send_sample(b);
        send_sample(c);
        wait_idle(300);
        check("overrun_one", 32'(bus.overrun_cnt), 32'd1);
        pulse_clear();
        #1;
        check("overrun_cleared", 32'(bus.overrun_cnt), 32'd0);

        // Reset mid-FILTER with a sample pending.
        done_delay = 20;
        a = DW'($urandom);
        exp_kf.push_back(a);
        send_sample(a);
        send_sample(DW'($urandom));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rst_gen++;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("post_reset_idle", 32'(bus.busy), 32'd0);
        done_delay = 5;
        c = DW'($urandom);
        exp_kf.push_back(c);
        exp_tx.push_back(filt(c));
        send_sample(c);
        wait_idle(200);

`ifdef KSEQ_WATCHDOG_EN
        // Filter never answers: watchdog aborts, later done is ignored.
        hold_filter = 1'b1;
        v = DW'($urandom);
        exp_kf.push_back(v);
        n0 = tx_count;
        send_sample(v);
        repeat (WD - 10) @(posedge clk);
        #1;
        check("wdog_before_err", 32'(bus.err_timeout), 32'd0);
        check("wdog_before_busy", 32'(bus.busy), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("wdog_err", 32'(bus.err_timeout), 32'd1);
        check("wdog_idle", 32'(bus.busy), 32'd0);
        hold_filter = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("wdog_err_sticky", 32'(bus.err_timeout), 32'd1);
        check("wdog_no_tx", 32'(tx_count), 32'(n0));
        pulse_clear();
        #1;
        check("wdog_err_cleared", 32'(bus.err_timeout), 32'd0);
`else
        // Without the watchdog FILTER waits indefinitely.
        hold_filter = 1'b1;
        v = DW'($urandom);
        exp_kf.push_back(v);
        send_sample(v);
        repeat (WD + 20) @(posedge clk);
        #1;
        check("nowdog_busy", 32'(bus.busy), 32'd1);
        check("nowdog_err", 32'(bus.err_timeout), 32'd0);
        exp_tx.push_back(filt(v));
        hold_filter = 1'b0;
        wait_idle(200);

        // 300 overruns saturate the counter at all-ones.
        hold_filter = 1'b1;
        v = DW'($urandom);
        exp_kf.push_back(v);
        exp_tx.push_back(filt(v));
        send_sample(v);
        last = '0;
        for (int i = 1; i <= 301; i++) begin
            last = DW'($urandom);
            send_sample(last);
            if (i == 11) check("sat_count_10", 32'(bus.overrun_cnt), 32'd10);
            if (i == 256) check("sat_count_255", 32'(bus.overrun_cnt), 32'd255);
        end
        check("sat_count_final", 32'(bus.overrun_cnt), 32'hFF);
        exp_kf.push_back(last);
        exp_tx.push_back(filt(last));
        hold_filter = 1'b0;
        wait_idle(300);
        pulse_clear();
        #1;
        check("sat_cleared", 32'(bus.overrun_cnt), 32'd0);
`endif

        check("scoreboard_kf_empty", 32'(exp_kf.size()), 32'd0);
        check("scoreboard_tx_empty", 32'(exp_tx.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
